scan_display_mux: RTL
=====================

SCAN_DISPLAY_MUX -- requirements
Module: scan_display_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits; legal range 1..8.
REQ-002 Parameter CLK_DIV, default 100000: clock cycles per digit slot; legal range 16..2^20.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 digit_data  input  4*NUM_DIGITS  hex nibble per digit; digit i = bits [4i+3:4i].
REQ-006 dp_in  input  NUM_DIGITS  decimal point request per digit, active-high.
REQ-007 digit_en  input  NUM_DIGITS  per-digit enable; disabled digit stays dark during its slot.
REQ-008 load  input  1  one-cycle strobe; captures digit_data, dp_in and digit_en into the pending buffer.
REQ-009 brightness  input  4  duty level; 0 = 1/16 on-time, 15 = full on-time.
REQ-010 anode_ON  output  NUM_DIGITS  active-low digit select; at most one bit low.
REQ-011 seg  output  7  active-low segments, order {g,f,e,d,c,b,a}.
REQ-012 dp_n  output  1  active-low decimal point.
REQ-013 frame_done  output  1  one-cycle pulse at the end of each full scan frame.

Function
REQ-014 Prescaler counts 0..CLK_DIV-1 and wraps to 0; slot_end asserts when prescaler = CLK_DIV-1.
REQ-015 Digit index counts 0..NUM_DIGITS-1 and advances on slot_end; from NUM_DIGITS-1 it wraps to 0.
REQ-016 frame_done pulses high for exactly one cycle, in the cycle after slot_end with index = NUM_DIGITS-1.
REQ-017 Active digit is lit when all three hold: prescaler != 0 (one-cycle anti-ghost blank), prescaler < ((brightness+1)*CLK_DIV)>>4, and active digit_en[index] = 1.
REQ-018 When the active digit is lit, anode_ON[index] = 0 and all other anode bits = 1; when it is not lit, anode_ON is all ones.
REQ-019 seg shows the hex decode of the active nibble[index]: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-020 dp_n = ~active dp[index] whenever the digit is lit; seg and dp_n are all ones whenever anode_ON is all ones.
REQ-021 anode_ON, seg, dp_n and frame_done are registered; they reflect the prescaler and index values of the previous cycle (one-cycle latency).
REQ-022 load copies its inputs into the pending buffer and sets pending_valid; a later load before the transfer overwrites the buffer (last load wins).
REQ-023 At the frame boundary (slot_end with index = NUM_DIGITS-1), if pending_valid = 1, pending is copied into the active buffer and pending_valid clears; the display never changes data mid-frame.
REQ-024 If load coincides with the frame boundary, the load inputs go directly into the active buffer and pending_valid ends at 0.
REQ-025 brightness is sampled every cycle, with no shadowing; a change takes effect on the next cycle's compare.
REQ-026 With NUM_DIGITS = 1, index stays 0 and frame_done pulses once per slot.

Reset
REQ-027 While rst_n = 0: prescaler = 0, index = 0, and the active and pending buffers, digit_en and pending_valid are all 0; anode_ON is all ones, seg = 1111111, dp_n = 1, frame_done = 0.
REQ-028 Reset asserted mid-frame forces the REQ-027 values immediately (asynchronous) and discards any pending load.
REQ-029 After rst_n deasserts, scanning restarts at index 0, prescaler 0; the display stays dark until the first load has transferred.

Verification (NUM_DIGITS=4, CLK_DIV=16)
REQ-030 Scenario: load digit_data=16'h3A7F, digit_en=4'hF, brightness=15 -> after the next frame boundary, slots 0..3 show seg 0001110, 1111000, 0001000, 0110000, with anode_ON 1110, 1101, 1011, 0111; a one-cycle blank precedes each slot.
REQ-031 Scenario: brightness=3 -> each slot has anode low for prescaler 1..3 only (3 cycles lit, 13 dark); brightness=0 -> lit for 0 cycles with CLK_DIV=16.
REQ-032 Scenario: digit_en=4'b1010 -> anode_ON stays 1111 during slots 0 and 2; frame_done pulses every 64 cycles.
REQ-033 Scenario: load 16'h1111 mid-frame, then load 16'h2222 before the boundary -> the current frame keeps the old data; the next frame shows 2 on all digits.
REQ-034 Scenario: load asserted on the boundary cycle with 16'h0000 -> frame starting at index 0 shows 1000000 on every digit; pending_valid = 0.
REQ-035 Scenario: rst_n pulled low during slot 2 -> outputs go to anode_ON=1111, seg=1111111 without waiting for clk; after release the display is dark until a new load transfers.

Source files
------------

// File: rtl/scan_display_mux.sv
// scan_display_mux: time-multiplexed 7-segment driver with PWM brightness
// and a pending buffer that is handed to the display only at frame boundaries.
module scan_display_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  input  logic [3:0]              brightness,
  output logic [NUM_DIGITS-1:0]   anode_ON,
  output logic [6:0]              seg,
  output logic                    dp_n,
  output logic                    frame_done
);
  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [PW-1:0]           presc_q, presc_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, act_data_q;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_en_q, act_dp_q, act_en_q;
  logic                    pend_valid_q;
  logic                    slot_end, boundary, lit;
  logic [24:0]             on_limit;
  logic [3:0]              nibble;
  always_comb begin
    slot_end = presc_q == PW'(CLK_DIV - 1);
    boundary = slot_end && idx_q == IW'(NUM_DIGITS - 1);
    presc_d  = slot_end ? '0 : presc_q + 1'b1;
    idx_d    = slot_end ? (boundary ? '0 : idx_q + 1'b1) : idx_q;
    on_limit = ((25'(brightness) + 25'd1) * 25'(CLK_DIV)) >> 4;
    // prescaler 0 is always dark so the anode switch never ghosts the previous digit
    lit      = presc_q != '0 && 25'(presc_q) < on_limit && act_en_q[idx_q];
    nibble   = act_data_q[{idx_q, 2'b00} +: 4];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      idx_q        <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      act_data_q   <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      pend_valid_q <= 1'b0;
      anode_ON     <= '1;
      seg          <= '1;
      dp_n         <= 1'b1;
      frame_done   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      frame_done <= boundary;
      anode_ON   <= lit ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      seg        <= lit ? SEG_LUT[nibble] : '1;
      dp_n       <= ~(lit && act_dp_q[idx_q]);
      if (load) begin
        pend_data_q <= digit_data;
        pend_dp_q   <= dp_in;
        pend_en_q   <= digit_en;
      end
      // a load on the boundary bypasses the pending buffer entirely
      if (boundary && (load || pend_valid_q)) begin
        act_data_q <= load ? digit_data : pend_data_q;
        act_dp_q   <= load ? dp_in : pend_dp_q;
        act_en_q   <= load ? digit_en : pend_en_q;
      end
      pend_valid_q <= boundary ? 1'b0 : (load || pend_valid_q);
    end
  end
endmodule
